cordic_delta_i_gen: RTL and testbench

Rotation-direction generator for one circular-mode CORDIC angle datapath.
- Holds the residual angle e_i, a signed two's-complement value, in a register.
- On a load it captures the target angle theta.
- On every other clock it subtracts or adds the supplied elementary angle alpha_i.
- It outputs the rotation direction delta, the sign of the residual, which steers the companion x/y shift-add stages.

---
 rtl/cordic_delta_i_gen.sv | 64 ++++++
 tb/tb_cordic_delta_i_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cordic_delta_i_gen.sv
`default_nettype none
// ============================================================================
// Module      : cordic_delta_i_gen
// Description : Residual-angle register and rotation-direction (sign) output
//               for a circular-mode CORDIC angle datapath. Define
//               CORDIC_DELTA_DBG_EN to expose the residual registers.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_delta_i_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] theta,
    input  logic [WIDTH-1:0] alpha_i,
    input  logic             async_LD,
`ifdef CORDIC_DELTA_DBG_EN
    output logic [WIDTH-1:0] e_i,
    output logic [WIDTH-1:0] e_i1,
`endif
    output logic             delta
);

    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] w_e_step;

    // Sign of the residual picks the direction; a zero residual subtracts.
    always_comb begin
        w_e_step = r_e - alpha_i;
        if (r_e[WIDTH-1]) begin
            w_e_step = r_e + alpha_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e <= '0;
        end else if (async_LD) begin
            r_e <= theta;
        end else begin
            r_e <= w_e_step;
        end
    end

    assign delta = r_e[WIDTH-1];

`ifdef CORDIC_DELTA_DBG_EN
    logic [WIDTH-1:0] r_e_prev;

    // Previous residual only advances on edges where the residual really moves.
    always_ff @(posedge clk) begin
        if (rst || async_LD) begin
            r_e_prev <= '0;
        end else if (w_e_step != r_e) begin
            r_e_prev <= r_e;
        end
    end

    assign e_i  = r_e;
    assign e_i1 = r_e_prev;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_delta_i_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_delta_i_gen
// Description : Directed scoreboard bench for cordic_delta_i_gen (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_delta_i_gen;

    localparam int WIDTH = 16;

    typedef struct {
        string            tag;
        logic             d;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] e1;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] theta;
    logic [WIDTH-1:0] alpha_i;
    logic             async_LD;
    logic             delta;
`ifdef CORDIC_DELTA_DBG_EN
    logic [WIDTH-1:0] e_i;
    logic [WIDTH-1:0] e_i1;
`endif

    exp_t             sb_q[$];
    int               n_checks;
    int               n_fails;
    logic [WIDTH-1:0] m_cur;
    logic [WIDTH-1:0] m_prev;

    cordic_delta_i_gen #(.WIDTH(WIDTH)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .theta    (theta),
        .alpha_i  (alpha_i),
        .async_LD (async_LD),
`ifdef CORDIC_DELTA_DBG_EN
        .e_i      (e_i),
        .e_i1     (e_i1),
`endif
        .delta    (delta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one edge's inputs, queue the expected result, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic ld,
                        input int th, input int al, input int exp_e);
        exp_t x;
        exp_t got;
        logic [WIDTH-1:0] nxt;
        @(negedge clk);
        rst      = r;
        async_LD = ld;
        theta    = WIDTH'(th);
        alpha_i  = WIDTH'(al);
        nxt      = WIDTH'(exp_e);
        if (r || ld) begin
            m_prev = '0;
        end else if (nxt != m_cur) begin
            m_prev = m_cur;
        end
        m_cur = nxt;
        x.tag = tag;
        x.e   = nxt;
        x.d   = nxt[WIDTH-1];
        x.e1  = m_prev;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        n_checks++;
        assert (delta === got.d) else begin
            n_fails++;
            $error("FAIL %s delta observed %b expected %b", got.tag, delta, got.d);
        end
`ifdef CORDIC_DELTA_DBG_EN
        n_checks++;
        assert (e_i === got.e) else begin
            n_fails++;
            $error("FAIL %s e_i observed %0d expected %0d", got.tag, $signed(e_i), $signed(got.e));
        end
        n_checks++;
        assert (e_i1 === got.e1) else begin
            n_fails++;
            $error("FAIL %s e_i1 observed %0d expected %0d", got.tag, $signed(e_i1), $signed(got.e1));
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        m_cur    = '0;
        m_prev   = '0;
        rst      = 1'b1;
        async_LD = 1'b1;
        theta    = 16'd35;
        alpha_i  = '0;

        // Reset wins over load
        step("rst0", 1, 1, 35, 0, 0);
        step("rst1", 1, 1, 35, 0, 0);
        // Load and the documented iteration sequence
        step("load35", 0, 1, 35, 0, 35);
        step("it_a20", 0, 0, 0, 20, 15);
        step("it_a17", 0, 0, 0, 17, -2);
        step("it_a15", 0, 0, 0, 15, 13);
        step("it_a12", 0, 0, 0, 12, 1);
        step("it_a4",  0, 0, 0, 4, -3);
        step("it_a1",  0, 0, 0, 1, -2);
        // Reload mid-sequence ignores alpha on that edge
        step("reload40", 0, 1, 40, 9, 40);
        step("alpha0_hold", 0, 0, 0, 0, 40);
        // Zero boundary
        step("load0", 0, 1, 0, 5, 0);
        step("zero_sub", 0, 0, 0, 5, -5);
        step("neg_add", 0, 0, 0, 5, 0);
        step("zero_hold", 0, 0, 0, 0, 0);
        // Most negative value
        step("loadmin", 0, 1, -32768, 0, -32768);
        step("min_add", 0, 0, 0, 100, -32668);
        // Wrap-region cases
        step("loadmax", 0, 1, 32767, 1, 32767);
        step("max_sub", 0, 0, 0, 1, 32766);
        step("load_m1", 0, 1, -1, 32767, -1);
        step("m1_add", 0, 0, 0, 32767, 32766);
        step("wrap_sub", 0, 0, 0, 32767, -1);
        // Load held high reloads every cycle
        step("hold_ld0", 0, 1, 7, 3, 7);
        step("hold_ld1", 0, 1, 7, 3, 7);
        step("step7", 0, 0, 0, 3, 4);
        // Reset mid-operation, then iteration continues from zero
        step("mid_rst", 1, 0, 0, 3, 0);
        step("post_rst", 0, 0, 0, 3, -3);

        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fails++;
            $error("FAIL sb_empty observed %0d entries expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
